// File: rtl/reg_op_unit.sv
// reg_op_unit: small register file with a single-issue ALU and a shift-add multiplier.
//
// An operation is accepted on a rising edge in IDLE when start is high. Its
// mode, addresses and operands are captured on that edge.
// - Modes 1-7 write Rz on the accepting edge.
// - MUL walks the multiplier one bit per cycle and writes Rz WIDTH edges later.
// - Every accepted request, including NOP and illegal modes, ends in DONE for one
//   cycle, and done is high during that cycle.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset (reloads registers from init_data)
//   init_data     reset image, register i = init_data[i*WIDTH +: WIDTH]
//   start, mode   operation request and select (0 NOP .. 8 MUL, 9-15 illegal)
//   rx, ry, rz    source / destination register addresses
//   rd_addr       debug read address; rd_data is the combinational register content
//   busy          multiply in flight
//   done          one-cycle completion pulse
//   err           one-cycle pulse, coincident with done, for an illegal mode
//   cy, zero      flags of the last result-producing operation
module reg_op_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DEPTH*WIDTH-1:0] init_data,
  input  logic                   start,
  input  logic [3:0]             mode,
  input  logic [AW-1:0]          rx,
  input  logic [AW-1:0]          ry,
  input  logic [AW-1:0]          rz,
  input  logic [AW-1:0]          rd_addr,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   busy,
  output logic                   done,
  output logic                   cy,
  output logic                   zero,
  output logic                   err
);

  localparam int unsigned SW = $clog2(WIDTH);

  localparam logic [3:0] ModeNop = 4'd0;
  localparam logic [3:0] ModeAdd = 4'd1;
  localparam logic [3:0] ModeSub = 4'd2;
  localparam logic [3:0] ModeAnd = 4'd3;
  localparam logic [3:0] ModeOr  = 4'd4;
  localparam logic [3:0] ModeXor = 4'd5;
  localparam logic [3:0] ModeShl = 4'd6;
  localparam logic [3:0] ModeShr = 4'd7;
  localparam logic [3:0] ModeMul = 4'd8;

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     regs_q [DEPTH];
  logic                 cy_q, cy_d, zero_q, zero_d, err_q, err_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d, acc_q, acc_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [SW-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]        rz_q, rz_d;

  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [WIDTH-1:0]     wr_data;
  logic                 wr_cy;

  logic [WIDTH-1:0]     op_a, op_b;
  logic [SW-1:0]        sh;
  logic [WIDTH:0]       sum, diff;
  logic [2*WIDTH-1:0]   shl_w, shr_w, prod;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_cy;

  assign op_a    = regs_q[rx];
  assign op_b    = regs_q[ry];
  assign sh      = op_b[SW-1:0];
  assign rd_data = regs_q[rd_addr];

  // Single-cycle datapath. Shifts run in a double-width window so the last bit
  // shifted out lands at a fixed position: bit WIDTH for SHL, bit WIDTH-1 for SHR.
  always_comb begin
    sum     = {1'b0, op_a} + {1'b0, op_b};
    diff    = {1'b0, op_a} - {1'b0, op_b};
    shl_w   = {{WIDTH{1'b0}}, op_a} << sh;
    shr_w   = {op_a, {WIDTH{1'b0}}} >> sh;
    alu_res = '0;
    alu_cy  = 1'b0;
    unique case (mode)
      ModeAdd: {alu_cy, alu_res} = sum;
      ModeSub: {alu_cy, alu_res} = diff;
      ModeAnd: alu_res = op_a & op_b;
      ModeOr:  alu_res = op_a | op_b;
      ModeXor: alu_res = op_a ^ op_b;
      ModeShl: begin
        alu_res = shl_w[WIDTH-1:0];
        alu_cy  = shl_w[WIDTH];
      end
      ModeShr: begin
        alu_res = shr_w[2*WIDTH-1:WIDTH];
        alu_cy  = shr_w[WIDTH-1];
      end
      default: ;
    endcase
  end

  assign prod = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    cy_d     = cy_q;
    zero_d   = zero_q;
    err_d    = err_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    rz_d     = rz_q;
    wr_en    = 1'b0;
    wr_addr  = rz;
    wr_data  = alu_res;
    wr_cy    = alu_cy;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StDone;
          unique case (mode)
            ModeNop: ;
            ModeAdd, ModeSub, ModeAnd, ModeOr, ModeXor, ModeShl, ModeShr: wr_en = 1'b1;
            ModeMul: begin
              state_d  = StMul;
              mcand_d  = {{WIDTH{1'b0}}, op_a};
              mplier_d = op_b;
              acc_d    = '0;
              cnt_d    = '0;
              rz_d     = rz;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      StMul: begin
        acc_d    = prod;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SW'(WIDTH - 1)) begin
          state_d = StDone;
          wr_en   = 1'b1;
          wr_addr = rz_q;
          wr_data = prod[WIDTH-1:0];
          wr_cy   = |prod[2*WIDTH-1:WIDTH];
        end
      end
      StDone: begin
        state_d = StIdle;
        err_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
    if (wr_en) begin
      cy_d   = wr_cy;
      zero_d = (wr_data == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cy_q     <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      rz_q     <= '0;
    end else begin
      state_q  <= state_d;
      cy_q     <= cy_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      rz_q     <= rz_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= init_data[i*WIDTH +: WIDTH];
      end
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  assign busy = (state_q == StMul);
  assign done = (state_q == StDone);
  assign err  = err_q;
  assign cy   = cy_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_reg_op_unit.sv
module tb_reg_op_unit;
  localparam int W  = 32;
  localparam int D  = 16;
  localparam int AW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [D*W-1:0]   init_data;
  logic             start;
  logic [3:0]       mode;
  logic [AW-1:0]    rx, ry, rz, rd_addr;
  logic [W-1:0]     rd_data;
  logic             busy, done, cy, zero, err;

  reg_op_unit #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .init_data(init_data), .start(start), .mode(mode),
    .rx(rx), .ry(ry), .rz(rz), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .cy(cy), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  logic [W-1:0] init_vals [D];
  logic [W-1:0] model [D];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  mode;
    logic [3:0]  rx, ry, rz;
    logic        wr;
    logic [31:0] res;
    logic        cy, zero, err;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sweep the debug port over every register; only used while idle.
  task automatic check_all(input string tag);
    for (int i = 0; i < D; i++) begin
      rd_addr = 4'(i);
      #1;
      chk($sformatf("%s R%0d", tag, i), rd_data, model[i]);
    end
    step();
  endtask

  task automatic apply_vec(input int k);
    vec_t v;
    v = vecs[k];
    start = 1'b1; mode = v.mode; rx = v.rx; ry = v.ry; rz = v.rz; rd_addr = v.rz;
    #1;
    chk($sformatf("v%0d old rz", k), rd_data, model[v.rz]);
    step();
    start = 1'b0; mode = 4'd1; rx = 4'd0; ry = 4'd0; rz = 4'd0;
    if (v.wr) model[v.rz] = v.res;
    chk($sformatf("v%0d done", k), done, 1'b1);
    chk($sformatf("v%0d err", k), err, v.err);
    chk($sformatf("v%0d busy", k), busy, 1'b0);
    chk($sformatf("v%0d result", k), rd_data, model[v.rz]);
    chk($sformatf("v%0d cy", k), cy, v.cy);
    chk($sformatf("v%0d zero", k), zero, v.zero);
    step();
    chk($sformatf("v%0d done low", k), done, 1'b0);
    chk($sformatf("v%0d err low", k), err, 1'b0);
    check_all($sformatf("v%0d", k));
  endtask

  task automatic mul_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                        input logic [31:0] exp, input logic ecy, input logic ezero,
                        input bit disturb);
    int n;
    int dones;
    start = 1'b1; mode = 4'd8; rx = a; ry = b; rz = d; rd_addr = d;
    step();
    start = 1'b0;
    chk("mul busy after accept", busy, 1'b1);
    n = 0;
    dones = 0;
    while (busy === 1'b1 && n < 40) begin
      chk($sformatf("mul old rz c%0d", n), rd_data, model[d]);
      if (done === 1'b1) dones++;
      if (disturb && n == 5) begin
        start = 1'b1; mode = 4'd1; rx = 4'd2; ry = 4'd2; rz = 4'd3;
      end
      if (disturb && n == 6) begin
        start = 1'b0; rx = 4'd9; ry = 4'd8;
      end
      n++;
      step();
    end
    start = 1'b0;
    model[d] = exp;
    chk("mul busy cycles", 64'(n), 64'd32);
    chk("mul done during busy", 64'(dones), 64'd0);
    chk("mul done", done, 1'b1);
    chk("mul result", rd_data, exp);
    chk("mul cy", cy, ecy);
    chk("mul zero", zero, ezero);
    chk("mul err", err, 1'b0);
    step();
    chk("mul done low", done, 1'b0);
    chk("mul busy low", busy, 1'b0);
    check_all("mul");
    chk("mul no extra done", done, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < D; i++) init_vals[i] = 32'h1000_0000 | 32'(i);
    init_vals[2]  = 32'd6;
    init_vals[3]  = 32'd7;
    init_vals[8]  = 32'hFFFF_FFFF;
    init_vals[9]  = 32'd1;
    init_vals[11] = 32'd5;
    init_vals[15] = 32'hFFFF_FFFF;
    for (int i = 0; i < D; i++) begin
      init_data[i*W +: W] = init_vals[i];
      model[i] = init_vals[i];
    end

    //          mode   rx     ry     rz     wr    res            cy    zero  err
    vecs[0]  = '{4'd1, 4'd8,  4'd9,  4'd10, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{4'd2, 4'd10, 4'd11, 4'd6,  1'b1, 32'hFFFF_FFFB, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{4'd3, 4'd8,  4'd11, 4'd12, 1'b1, 32'h0000_0005, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{4'd5, 4'd8,  4'd8,  4'd7,  1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{4'd0, 4'd3,  4'd3,  4'd0,  1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{4'd4, 4'd2,  4'd3,  4'd13, 1'b1, 32'h0000_0007, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'd6, 4'd8,  4'd9,  4'd1,  1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{4'hF, 4'd8,  4'd9,  4'd0,  1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{4'd7, 4'd11, 4'd9,  4'd0,  1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{4'd7, 4'd13, 4'd12, 4'd13, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{4'd6, 4'd2,  4'd7,  4'd5,  1'b1, 32'h0000_0006, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'd1, 4'd9,  4'd9,  4'd9,  1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{4'd6, 4'd15, 4'd11, 4'd14, 1'b1, 32'hFFFF_FFE0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{4'd7, 4'd15, 4'd8,  4'd5,  1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; mode = 4'd0;
    rx = '0; ry = '0; rz = '0; rd_addr = '0;
    step();
    step();
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset cy", cy, 1'b0);
    chk("reset zero", zero, 1'b0);
    chk("reset err", err, 1'b0);
    rst = 1'b0;
    check_all("reset");

    for (int k = 0; k < 14; k++) apply_vec(k);

    mul_op(4'd2, 4'd3, 4'd4, 32'd42, 1'b0, 1'b0, 1'b0);
    mul_op(4'd15, 4'd15, 4'd14, 32'd1, 1'b1, 1'b0, 1'b1);

    // Abort a multiply with reset; a start presented with the reset must be dropped.
    start = 1'b1; mode = 4'd8; rx = 4'd2; ry = 4'd3; rz = 4'd4; rd_addr = 4'd4;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("abort busy before rst", busy, 1'b1);
    rst = 1'b1; start = 1'b1; mode = 4'd1; rx = 4'd8; ry = 4'd9; rz = 4'd10;
    step();
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < D; i++) model[i] = init_vals[i];
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort cy", cy, 1'b0);
    chk("abort zero", zero, 1'b0);
    chk("abort err", err, 1'b0);
    step();
    chk("abort no late done", done, 1'b0);
    chk("abort no late busy", busy, 1'b0);
    for (int i = 0; i < 25; i++) step();
    chk("abort R4 kept", rd_data, init_vals[4]);
    check_all("abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
